// File: rtl/exe_mem_reg.sv
// exe_mem_reg: EXE->MEM pipeline register for a MIPS-style pipeline.
// Captures the EXE-stage instruction, checks load/store alignment, merges
// the alignment fault into the exception flags, and pre-computes byte
// enables and lane-replicated store data for the data memory port.
// Every MEM_* output is driven straight from flops. EXE_Ready is the only
// output with a combinational path, and it depends only on MEM_Stall.
module exe_mem_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        EXE_Valid,
   input  logic [31:0] EXE_ALUOut,
   input  logic [8:0]  EXE_ExceptType,
   input  logic [31:0] EXE_PC,
   input  logic [31:0] EXE_StoreData,
   input  logic [3:0]  EXE_MemOp,
   input  logic        EXE_RegWr,
   input  logic [4:0]  EXE_Dst,
   input  logic        MEM_Stall,
   input  logic        MEM_Flush,
   output logic        EXE_Ready,
   output logic        MEM_Valid,
   output logic [31:0] MEM_ALUOut,
   output logic [31:0] MEM_PC,
   output logic [3:0]  MEM_MemOp,
   output logic [4:0]  MEM_Dst,
   output logic [8:0]  MEM_ExceptType,
   output logic        MEM_HasExcept,
   output logic [31:0] MEM_StoreData,
   output logic [3:0]  MEM_ByteEn,
   output logic        MEM_MemRd,
   output logic        MEM_MemWr,
   output logic        MEM_RegWr
);

   // Memory operation encoding. Codes 9-15 are treated as no access.
   typedef enum logic [3:0] {
      MOP_NONE = 4'd0,
      MOP_LB   = 4'd1,
      MOP_LBU  = 4'd2,
      MOP_LH   = 4'd3,
      MOP_LHU  = 4'd4,
      MOP_LW   = 4'd5,
      MOP_SB   = 4'd6,
      MOP_SH   = 4'd7,
      MOP_SW   = 4'd8
   } mem_op_e;

   // Bit positions of the alignment faults in the exception vector.
   localparam int unsigned EXC_WR_ADDR = 2;
   localparam int unsigned EXC_RD_ADDR = 1;

   // Contents of the MEM stage. An all-zero value is the bubble.
   typedef struct packed {
      logic        valid;
      logic [31:0] alu_out;
      logic [31:0] pc;
      logic [3:0]  mem_op;
      logic [4:0]  dst;
      logic [8:0]  except_type;
      logic [31:0] store_data;
      logic [3:0]  byte_en;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } stage_t;

   stage_t stage_q, stage_d;

   logic        is_load;
   logic        is_store;
   logic        misaligned;
   logic [3:0]  byte_en_raw;
   logic [31:0] store_data_raw;
   logic [8:0]  except_merged;
   logic        has_except;

   assign EXE_Ready = !MEM_Stall;

   // Decode the EXE memory op: access type, alignment, lanes and store data.
   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case can leave one unassigned and infer a latch.
   always_comb begin
      is_load        = 1'b0;
      is_store       = 1'b0;
      misaligned     = 1'b0;
      byte_en_raw    = 4'b0000;
      store_data_raw = 32'h0;
      case (EXE_MemOp)
         MOP_LB, MOP_LBU: begin
            is_load     = 1'b1;
            byte_en_raw = 4'b0001 << EXE_ALUOut[1:0];
         end
         MOP_LH, MOP_LHU: begin
            is_load     = 1'b1;
            misaligned  = EXE_ALUOut[0];
            byte_en_raw = EXE_ALUOut[1] ? 4'b1100 : 4'b0011;
         end
         MOP_LW: begin
            is_load     = 1'b1;
            misaligned  = |EXE_ALUOut[1:0];
            byte_en_raw = 4'b1111;
         end
         MOP_SB: begin
            is_store       = 1'b1;
            byte_en_raw    = 4'b0001 << EXE_ALUOut[1:0];
            store_data_raw = {4{EXE_StoreData[7:0]}};
         end
         MOP_SH: begin
            is_store       = 1'b1;
            misaligned     = EXE_ALUOut[0];
            byte_en_raw    = EXE_ALUOut[1] ? 4'b1100 : 4'b0011;
            store_data_raw = {2{EXE_StoreData[15:0]}};
         end
         MOP_SW: begin
            is_store       = 1'b1;
            misaligned     = |EXE_ALUOut[1:0];
            byte_en_raw    = 4'b1111;
            store_data_raw = EXE_StoreData;
         end
         default: ;
      endcase
   end

   // Merge alignment faults into the incoming exception flags.
   always_comb begin
      except_merged              = EXE_ExceptType;
      except_merged[EXC_RD_ADDR] = EXE_ExceptType[EXC_RD_ADDR] | (is_load & misaligned);
      except_merged[EXC_WR_ADDR] = EXE_ExceptType[EXC_WR_ADDR] | (is_store & misaligned);
      has_except                 = |except_merged;
   end

   // Build the next stage contents. An excepting instruction stays valid so
   // MEM can commit the exception, but every side effect is suppressed. The
   // address is still captured because it is the BadVAddr source.
   always_comb begin
      stage_d = '0;
      if (EXE_Valid) begin
         stage_d.valid       = 1'b1;
         stage_d.alu_out     = EXE_ALUOut;
         stage_d.pc          = EXE_PC;
         stage_d.mem_op      = EXE_MemOp;
         stage_d.dst         = EXE_Dst;
         stage_d.except_type = except_merged;
         stage_d.store_data  = store_data_raw;
         stage_d.byte_en     = has_except ? 4'b0000 : byte_en_raw;
         stage_d.mem_rd      = is_load  & !has_except;
         stage_d.mem_wr      = is_store & !has_except;
         stage_d.reg_wr      = EXE_RegWr & !has_except;
      end
   end

   // Stage register. Priority: reset, then flush, then stall, then capture.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the values from before the clock edge.
   // NOTE: the reset is asynchronous, so the outputs clear without a clock
   // edge. The stage holds only a few flops, so all of them are reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else if (MEM_Flush) begin
         stage_q <= '0;
      end else if (!MEM_Stall) begin
         stage_q <= stage_d;
      end
   end

   assign MEM_Valid      = stage_q.valid;
   assign MEM_ALUOut     = stage_q.alu_out;
   assign MEM_PC         = stage_q.pc;
   assign MEM_MemOp      = stage_q.mem_op;
   assign MEM_Dst        = stage_q.dst;
   assign MEM_ExceptType = stage_q.except_type;
   assign MEM_HasExcept  = |stage_q.except_type;
   assign MEM_StoreData  = stage_q.store_data;
   assign MEM_ByteEn     = stage_q.byte_en;
   assign MEM_MemRd      = stage_q.mem_rd;
   assign MEM_MemWr      = stage_q.mem_wr;
   assign MEM_RegWr      = stage_q.reg_wr;

endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 SHALL have ports: clk, rst; clock/reset: one clock, reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 EXE_Valid  in  1  EXE slot holds a real instruction.
REQ-005 EXE_ALUOut  in  32  ALU result / effective address.
REQ-006 EXE_ExceptType  in  9  exception flags, MSB..LSB: Interrupt, WrongAddressinIF, ReservedInstruction, Syscall, Break, Eret, WrWrongAddressinMEM, RdWrongAddressinMEM, Overflow.
REQ-007 EXE_PC  in  32  instruction PC.
REQ-008 EXE_StoreData  in  32  rt value for stores.
REQ-009 EXE_MemOp  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
REQ-010 EXE_RegWr  in  1  writes GPR; EXE_Dst  in  5  destination register.
REQ-011 MEM_Stall  in  1  hold MEM stage; MEM_Flush  in  1  kill MEM stage contents.
REQ-012 EXE_Ready  out  1  stage accepts a new instruction this cycle.
REQ-013 MEM_Valid  out  1; MEM_ALUOut  out  32; MEM_PC  out  32; MEM_MemOp  out  4; MEM_Dst  out  5 (registered copies).
REQ-014 MEM_ExceptType  out  9  merged exception flags; MEM_HasExcept  out  1  OR of MEM_ExceptType.
REQ-015 MEM_StoreData  out  32  lane-replicated store data; MEM_ByteEn  out  4  byte lanes.
REQ-016 MEM_MemRd  out  1; MEM_MemWr  out  1; MEM_RegWr  out  1.

Function
REQ-017 Latency SHALL be one cycle: values presented in EXE appear on MEM_* after the next rising clk edge.
REQ-018 EXE_Ready SHALL equal !MEM_Stall (combinational).
REQ-019 Edge priority SHALL be: rst > MEM_Flush > MEM_Stall > capture.
REQ-020 MEM_Flush=1 at an edge SHALL load the bubble state (all outputs zero), regardless of MEM_Stall.
REQ-021 MEM_Stall=1 (no flush) SHALL hold every registered output unchanged.
REQ-022 EXE_Valid=0 at a capture edge SHALL load the bubble state.
REQ-023 Alignment check on EXE_ALUOut: LH/LHU/SH need bit0=0; LW/SW need bits[1:0]=00; LB/LBU/SB always aligned.
REQ-024 Misaligned load SHALL set RdWrongAddressinMEM, misaligned store SHALL set WrWrongAddressinMEM, OR-ed with incoming flags; all other flags pass through unchanged.
REQ-025 ByteEn: SB/LB/LBU 4'b0001<<addr[1:0]; SH/LH/LHU addr[1]?4'b1100:4'b0011; SW/LW 4'b1111; none 4'b0000.
REQ-026 StoreData: SB replicates byte[7:0] x4; SH replicates half[15:0] x2; SW unchanged; non-stores 0.
REQ-027 MemRd=1 for MemOp 1-5, MemWr=1 for MemOp 6-8, else 0.
REQ-028 When merged exception nonzero, MemRd, MemWr, RegWr SHALL be 0 and ByteEn 4'b0000; MEM_ALUOut still captured (BadVAddr source).
REQ-029 MEM_Valid SHALL remain 1 for an excepting instruction so MEM can commit the exception.
REQ-030 No output SHALL depend combinationally on EXE_* except EXE_Ready.

Reset
REQ-031 rst=1 SHALL immediately (without clk) force all MEM_* outputs to 0; first capture occurs on first rising edge after rst deasserts.

Verification
REQ-032 rst pulsed mid-stream between edges -> all MEM_* read 0 immediately, stay 0 until next capture.
REQ-033 SW, ALUOut=0x10000004, StoreData=0xDEADBEEF -> MemWr=1, ByteEn=1111, StoreData=0xDEADBEEF, HasExcept=0.
REQ-034 SB, ALUOut=0x10000002, StoreData=0x000000AB -> ByteEn=0100, StoreData=0xABABABAB.
REQ-035 SH, ALUOut=0x10000003 -> WrWrongAddressinMEM=1, MemWr=0, ByteEn=0000, MEM_ALUOut=0x10000003, Valid=1.
REQ-036 ADD with incoming Overflow=1, RegWr=1 -> MEM_RegWr=0, Overflow=1, HasExcept=1.
REQ-037 MEM_Stall=1 for 3 cycles then MEM_Stall=1 with MEM_Flush=1 -> outputs held 3 cycles, then bubble.
